// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execute ALU; iterative mul, optional divider.
// Define ALU_DIV_EN to build the iterative divider for func 10/11.
module alu_mc #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       func,
   input  logic [5:0]       opcode,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic             zero_flag,
   output logic             busy
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] acc, q, opd;
   logic [WIDTH-1:0] res_new, res_hold;
   logic             zf_new, zf_hold;
   logic             ov_q, sel_hi, sel_div;
   logic [5:0]       op_q;
   logic             accept, is_multi, commit;
   logic [WIDTH-1:0] single, nxt_hi, nxt_lo, fin;
   logic [WIDTH:0]   sum;
`ifdef ALU_DIV_EN
   logic [WIDTH:0]   sh;
   logic [WIDTH:0]   df;
`endif

   function automatic logic zf(input logic [5:0] op,
                               input logic [WIDTH-1:0] r);
      return ((op == 6'b000100) && (r == '0)) ||
             ((op == 6'b000101) && (r != '0));
   endfunction

   assign in_ready = (state == IDLE) & ~flush;
   assign accept   = in_valid & in_ready;
   assign busy     = (state == RUN);

   // A flush in the pulse cycle retracts the op just produced.
   assign commit    = ov_q & ~flush;
   assign out_valid = commit;
   assign result    = commit ? res_new : res_hold;
   assign zero_flag = commit ? zf_new : zf_hold;

`ifdef ALU_DIV_EN
   assign is_multi = (func[3:2] == 2'b10);
`else
   assign is_multi = (func[3:1] == 3'b100);
`endif

   always_comb begin
      single = '0;
      case (func)
         4'd0: single = a + b;
         4'd1: single = a - b;
         4'd2: single = a & b;
         4'd3: single = a | b;
         4'd4: single = ~a;
         4'd5: single = a;
         4'd6: single = {{(WIDTH-1){1'b0}}, (a < b)};
         4'd7: single = b << (WIDTH/2);
         default: single = '0;
      endcase
   end

   // {acc,q} is the product (mul) or {remainder,quotient} (div).
   always_comb begin
      nxt_hi = acc;
      nxt_lo = q;
      sum    = '0;
`ifdef ALU_DIV_EN
      sh     = {acc, q[WIDTH-1]};
      df     = sh - {1'b0, opd};
`endif
      if (!sel_div) begin
         sum    = {1'b0, acc} + (q[0] ? {1'b0, opd} : '0);
         nxt_hi = sum[WIDTH:1];
         nxt_lo = {sum[0], q[WIDTH-1:1]};
      end
`ifdef ALU_DIV_EN
      else if (sh >= {1'b0, opd}) begin
         nxt_hi = df[WIDTH-1:0];
         nxt_lo = {q[WIDTH-2:0], 1'b1};
      end else begin
         nxt_hi = sh[WIDTH-1:0];
         nxt_lo = {q[WIDTH-2:0], 1'b0};
      end
`endif
      fin = sel_hi ? nxt_hi : nxt_lo;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         acc      <= '0;
         q        <= '0;
         opd      <= '0;
         res_new  <= '0;
         res_hold <= '0;
         zf_new   <= 1'b0;
         zf_hold  <= 1'b0;
         ov_q     <= 1'b0;
         sel_hi   <= 1'b0;
         sel_div  <= 1'b0;
         op_q     <= '0;
      end else begin
         ov_q <= 1'b0;
         if (commit) begin
            res_hold <= res_new;
            zf_hold  <= zf_new;
         end
         if (flush) begin
            state <= IDLE;
            cnt   <= '0;
         end else if (state == IDLE) begin
            if (accept && is_multi) begin
               state   <= RUN;
               cnt     <= CNT_W'(WIDTH);
               acc     <= '0;
               q       <= func[1] ? a : b;
               opd     <= func[1] ? b : a;
               sel_hi  <= func[0];
               sel_div <= func[1];
               op_q    <= opcode;
            end else if (accept) begin
               res_new <= single;
               zf_new  <= zf(opcode, single);
               ov_q    <= 1'b1;
            end
         end else begin
            acc <= nxt_hi;
            q   <= nxt_lo;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               state   <= IDLE;
               cnt     <= '0;
               res_new <= fin;
               zf_new  <= zf(op_q, fin);
               ov_q    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed checks of alu_mc at WIDTH=32.
// Divider vectors apply when ALU_DIV_EN is defined.
module tb_alu_mc;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [3:0]  func = '0;
   logic [5:0]  opcode = '0;
   logic        out_valid;
   logic [31:0] result;
   logic        zero_flag;
   logic        busy;
   int          total = 0;
   int          bad = 0;
   logic        ok;

   alu_mc #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .func(func), .opcode(opcode),
      .out_valid(out_valid), .result(result),
      .zero_flag(zero_flag), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Presents one op for a single clock edge; returns at the next negedge.
   task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                        input logic [3:0] f, input logic [5:0] op);
      a = ia; b = ib; func = f; opcode = op; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic multi(input string tag, input logic [31:0] ia,
                        input logic [31:0] ib, input logic [3:0] f,
                        input logic [31:0] exp);
      issue(ia, ib, f, 6'd0);
      ok = 1'b1;
      for (int i = 0; i < 32; i++) begin
         if (i > 0) @(negedge clk);
         if (!(busy === 1'b1 && in_ready === 1'b0 && out_valid === 1'b0))
            ok = 1'b0;
      end
      chk({tag, "_busy"}, {31'd0, ok}, 32'd1);
      @(negedge clk);
      chk({tag, "_ov"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_res"}, result, exp);
   endtask

   initial begin
      @(negedge clk);
      chk("rst_ov", {31'd0, out_valid}, 32'd0);
      chk("rst_res", result, 32'd0);
      chk("rst_zf", {31'd0, zero_flag}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      issue(32'd5, 32'd7, 4'd0, 6'd0);
      chk("add_ov", {31'd0, out_valid}, 32'd1);
      chk("add_res", result, 32'd12);
      chk("add_zf", {31'd0, zero_flag}, 32'd0);
      @(negedge clk);
      chk("add_ov_drop", {31'd0, out_valid}, 32'd0);
      chk("add_hold", result, 32'd12);

      issue(32'd9, 32'd9, 4'd1, 6'b000100);
      chk("beq_res", result, 32'd0);
      chk("beq_zf", {31'd0, zero_flag}, 32'd1);
      issue(32'd9, 32'd9, 4'd1, 6'b000101);
      chk("bne_zf", {31'd0, zero_flag}, 32'd0);
      issue(32'd0, 32'd1, 4'd1, 6'b000101);
      chk("sub_wrap", result, 32'hFFFF_FFFF);
      chk("bne_zf1", {31'd0, zero_flag}, 32'd1);
      issue(32'h0F0F_00FF, 32'h00FF_0F0F, 4'd2, 6'd0);
      chk("and", result, 32'h000F_000F);
      issue(32'h0F0F_00F0, 32'h00F0_0F0F, 4'd3, 6'd0);
      chk("or", result, 32'h0FFF_0FFF);
      issue(32'h0000_00FF, 32'd0, 4'd4, 6'd0);
      chk("not", result, 32'hFFFF_FF00);
      issue(32'hDEAD_BEEF, 32'd0, 4'd5, 6'd0);
      chk("mov", result, 32'hDEAD_BEEF);
      issue(32'd3, 32'hFFFF_FFFF, 4'd6, 6'd0);
      chk("slt_1", result, 32'd1);
      issue(32'hFFFF_FFFF, 32'd3, 4'd6, 6'd0);
      chk("slt_0", result, 32'd0);
      issue(32'd0, 32'h0000_1234, 4'd7, 6'd0);
      chk("lui", result, 32'h1234_0000);
      issue(32'd1, 32'd2, 4'd13, 6'd0);
      chk("func13", result, 32'd0);

      multi("mulh", 32'h0001_0000, 32'h0003_0000, 4'd9, 32'd3);
      multi("mul", 32'h0001_0000, 32'h0003_0000, 4'd8, 32'd0);
      multi("mulh_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd9, 32'hFFFF_FFFE);
      multi("mul_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd8, 32'd1);
      multi("mul_small", 32'd1234, 32'd5678, 4'd8, 32'd7006652);

      issue(32'd3, 32'd4, 4'd8, 6'd0);
      for (int i = 1; i < 10; i++) @(negedge clk);
      flush = 1'b1;
      #1 chk("flush_rdy_low", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("flush_rdy", {31'd0, in_ready}, 32'd1);
      chk("flush_busy", {31'd0, busy}, 32'd0);
      chk("flush_ov", {31'd0, out_valid}, 32'd0);
      chk("flush_res", result, 32'd7006652);
      ok = 1'b1;
      for (int i = 0; i < 36; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0) ok = 1'b0;
      end
      chk("flush_quiet", {31'd0, ok}, 32'd1);

      issue(32'd1, 32'd1, 4'd0, 6'd0);
      flush = 1'b1;
      #1;
      chk("iflush_ov", {31'd0, out_valid}, 32'd0);
      chk("iflush_res", result, 32'd7006652);
      @(negedge clk);
      flush = 1'b0;
      #1 chk("iflush_hold", result, 32'd7006652);

      a = 32'd1; b = 32'd1; func = 4'd0; opcode = 6'd0; in_valid = 1'b1;
      @(negedge clk);
      chk("b2b_ov1", {31'd0, out_valid}, 32'd1);
      chk("b2b_res1", result, 32'd2);
      a = 32'd2; b = 32'd2;
      @(negedge clk);
      in_valid = 1'b0;
      chk("b2b_ov2", {31'd0, out_valid}, 32'd1);
      chk("b2b_res2", result, 32'd4);

`ifdef ALU_DIV_EN
      multi("div", 32'd100, 32'd7, 4'd10, 32'd14);
      multi("rem", 32'd100, 32'd7, 4'd11, 32'd2);
      multi("div0", 32'd100, 32'd0, 4'd10, 32'hFFFF_FFFF);
      multi("rem0", 32'd100, 32'd0, 4'd11, 32'd100);
      multi("div_big", 32'hFFFF_FFFF, 32'd16, 4'd10, 32'h0FFF_FFFF);
`else
      issue(32'd100, 32'd7, 4'd10, 6'd0);
      chk("nodiv_ov", {31'd0, out_valid}, 32'd1);
      chk("nodiv_res", result, 32'd0);
      chk("nodiv_busy", {31'd0, busy}, 32'd0);
`endif

      issue(32'd5, 32'd6, 4'd3, 6'd0);
      chk("pre_rst", result, 32'd7);
      issue(32'd3, 32'd4, 4'd8, 6'd0);
      for (int i = 1; i < 5; i++) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("arst_res", result, 32'd0);
      chk("arst_ov", {31'd0, out_valid}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(32'd2, 32'd3, 4'd0, 6'd0);
      chk("post_rst", result, 32'd5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
